spi_target: RTL and testbench



---
 rtl/spi_target.sv | 214 +++++++++++++++++++++
 tb/tb_spi_target.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// SPI Mode-0 target: oversamples SCLK/CSB/MOSI in the wb_clk_i domain, shifts MSB-first words
// in and out, and exposes them on valid/ready RX and TX streams.
module spi_target #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              spi_sclk_i,
  input  logic              spi_csb_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oeb_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_overrun_o,
  output logic              tx_underrun_o,
  output logic              busy_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, csb_prev_q;
  logic                   sclk_s, csb_s, mosi_s;
  logic                   sclk_rise, sclk_fall, csb_fall, csb_rise;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              next_load_q, next_load_d;
  logic              miso_q, miso_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;

  logic              load_req;
  logic              word_done;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] load_word;

  // Synchronizer chains; edge detection compares the last two synchronized samples.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
    csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0], spi_csb_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sclk_sync_q <= '0;
      csb_sync_q  <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      csb_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      csb_sync_q  <= csb_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_s;
      csb_prev_q  <= csb_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csb_s     = csb_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csb_fall  = ~csb_s & csb_prev_q;
  assign csb_rise  = csb_s & ~csb_prev_q;

  assign rx_word   = {rx_sh_q[DATA_W-2:0], mosi_s};
  assign load_word = full_q ? hold_q : '0;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    next_load_d = next_load_q;
    miso_d      = miso_q;
    hold_d      = hold_q;
    full_d      = full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;
    underrun_d  = 1'b0;
    load_req    = 1'b0;
    word_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (csb_fall) begin
          state_d     = ST_SHIFT;
          load_req    = 1'b1;
          bit_cnt_d   = '0;
          rx_sh_d     = '0;
          next_load_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (csb_rise) begin
          // Partial RX bits and any TX word already in the shifter are abandoned.
          state_d     = ST_IDLE;
          miso_d      = 1'b0;
          bit_cnt_d   = '0;
          next_load_d = 1'b0;
        end else if (sclk_rise) begin
          rx_sh_d = rx_word;
          if (bit_cnt_q == LAST_BIT) begin
            word_done   = 1'b1;
            bit_cnt_d   = '0;
            next_load_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (next_load_q) begin
            load_req    = 1'b1;
            next_load_d = 1'b0;
          end else begin
            tx_sh_d = tx_sh_q << 1;
            miso_d  = tx_sh_q[DATA_W-2];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_req) begin
      tx_sh_d    = load_word;
      miso_d     = load_word[DATA_W-1];
      underrun_d = ~full_q;
    end

    // A load consumes a full holding register; a capture is only possible when it was empty,
    // so a same-cycle load and capture leaves the captured word waiting for the next load.
    if (load_req && full_q) begin
      full_d = 1'b0;
    end
    if (tx_valid_i && !full_q) begin
      hold_d = tx_data_i;
      full_d = 1'b1;
    end

    if (word_done) begin
      if (!rx_valid_q || rx_ready_i) begin
        rx_data_d  = rx_word;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_ready_i) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      next_load_q <= 1'b0;
      miso_q      <= 1'b0;
      hold_q      <= '0;
      full_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      next_load_q <= next_load_d;
      miso_q      <= miso_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
    end
  end

  assign spi_miso_o     = miso_q;
  assign spi_miso_oeb_o = (state_q != ST_SHIFT);
  assign busy_o         = (state_q == ST_SHIFT);
  assign tx_ready_o     = ~full_q;
  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_overrun_o   = overrun_q;
  assign tx_underrun_o  = underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a table of directed frames, hand-written partial-frame and reset
// sequences, and random frames checked against a word-level model of the SPI target.
module tb_spi_target;

  localparam int HALF = 4;

  logic       clk;
  logic       wb_rst_i;
  logic       spi_sclk, spi_csb, spi_mosi;
  logic       spi_miso_o, spi_miso_oeb_o;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, rx_ready_i;
  logic       rx_overrun_o, tx_underrun_o, busy_o;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         und_cnt = 0;
  int         ovr_cnt = 0;
  logic [7:0] rx_q[$];
  logic       mid_oeb, mid_busy;

  spi_target #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (wb_rst_i),
    .spi_sclk_i    (spi_sclk),
    .spi_csb_i     (spi_csb),
    .spi_mosi_i    (spi_mosi),
    .spi_miso_o    (spi_miso_o),
    .spi_miso_oeb_o(spi_miso_oeb_o),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready_o),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .rx_ready_i    (rx_ready_i),
    .rx_overrun_o  (rx_overrun_o),
    .tx_underrun_o (tx_underrun_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and RX handshake log, sampled mid-cycle.
  always @(negedge clk) begin
    if (!wb_rst_i) begin
      if (tx_underrun_o) und_cnt <= und_cnt + 1;
      if (rx_overrun_o) ovr_cnt <= ovr_cnt + 1;
      if (rx_valid_o && rx_ready_i) rx_q.push_back(rx_data_o);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tx_push(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready_o && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tx_push_timeout: tx_ready_o stayed %b, expected 1", tx_ready_o);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  // Controller side of one CSB frame; CSB rises together with the final SCLK fall.
  task automatic spi_xfer(input int nbits, input logic [31:0] mo, output logic [31:0] mi);
    mi = '0;
    tick();
    spi_csb  = 1'b0;
    spi_mosi = mo[nbits-1];
    repeat (HALF) tick();
    for (int i = 0; i < nbits; i++) begin
      spi_sclk = 1'b1;
      mi = {mi[30:0], spi_miso_o};
      if (i == 0) begin
        mid_oeb  = spi_miso_oeb_o;
        mid_busy = busy_o;
      end
      repeat (HALF) tick();
      spi_sclk = 1'b0;
      if (i == nbits - 1) spi_csb = 1'b1;
      else spi_mosi = mo[nbits-2-i];
      repeat (HALF) tick();
    end
    spi_mosi = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input int nb, input bit pre_en,
                               input logic [7:0] pre, input logic [1:0] push_en,
                               input logic [15:0] pdat, input logic [23:0] mosi, input bit rdy,
                               input logic [23:0] exp_miso, input int exp_und, input int exp_ovr,
                               input logic [7:0] exp_rx);
    int u0, o0, base;
    logic [31:0] mi;
    rx_ready_i = rdy;
    if (pre_en) begin
      tx_push(pre);
      chk1({tag, "_tx_ready_full"}, tx_ready_o, 1'b0);
    end
    u0   = und_cnt;
    o0   = ovr_cnt;
    base = rx_q.size();
    fork
      spi_xfer(nb * 8, {8'h00, mosi}, mi);
      begin
        int t;
        t = 0;
        for (int k = 0; k < nb - 1; k++) begin
          while (t < 64 * k + 20) begin
            tick();
            t++;
          end
          if (push_en[k]) begin
            tx_push(pdat[8*k +: 8]);
            t += 2;
          end
        end
      end
    join
    repeat (8) tick();
    chk({tag, "_miso_word"}, 32'(mi[23:0]), 32'(exp_miso));
    chk({tag, "_underruns"}, und_cnt - u0, exp_und);
    chk({tag, "_overruns"}, ovr_cnt - o0, exp_ovr);
    chk1({tag, "_oeb_in_frame"}, mid_oeb, 1'b0);
    chk1({tag, "_busy_in_frame"}, mid_busy, 1'b1);
    chk1({tag, "_oeb_after"}, spi_miso_oeb_o, 1'b1);
    chk1({tag, "_busy_after"}, busy_o, 1'b0);
    chk1({tag, "_miso_after"}, spi_miso_o, 1'b0);
    chk1({tag, "_tx_ready_after"}, tx_ready_o, 1'b1);
    chk({tag, "_rx_data"}, 32'(rx_data_o), 32'(exp_rx));
    if (rdy) begin
      chk({tag, "_rx_count"}, rx_q.size() - base, nb);
      for (int k = 0; k < nb; k++)
        if (base + k < rx_q.size())
          chk({tag, "_rx_word"}, 32'(rx_q[base+k]), 32'(mosi[8*(nb-1-k) +: 8]));
      chk1({tag, "_rx_valid_after"}, rx_valid_o, 1'b0);
    end else begin
      chk1({tag, "_rx_valid_held"}, rx_valid_o, 1'b1);
      rx_ready_i = 1'b1;
      tick();
      chk1({tag, "_rx_valid_drain"}, rx_valid_o, 1'b0);
      chk({tag, "_rx_data_drain"}, 32'(rx_data_o), 32'(exp_rx));
    end
  endtask

  typedef struct {
    string       tag;
    int          nb;
    bit          pre_en;
    logic [7:0]  pre;
    logic [1:0]  push_en;
    logic [15:0] pdat;
    logic [23:0] mosi;
    bit          rdy;
    logic [23:0] exp_miso;
    int          exp_und;
    int          exp_ovr;
    logic [7:0]  exp_rx;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] mi;
    int          base;

    tbl[0] = '{"basic",    1, 1'b1, 8'hA5, 2'b00, 16'h0000, 24'h00003C, 1'b1, 24'h0000A5, 0, 0, 8'h3C};
    tbl[1] = '{"b2b",      2, 1'b1, 8'h55, 2'b01, 16'h00AA, 24'h001234, 1'b1, 24'h0055AA, 0, 0, 8'h34};
    tbl[2] = '{"underrun", 1, 1'b0, 8'h00, 2'b00, 16'h0000, 24'h0000F0, 1'b1, 24'h000000, 1, 0, 8'hF0};
    tbl[3] = '{"overrun",  2, 1'b0, 8'h00, 2'b00, 16'h0000, 24'h001122, 1'b0, 24'h000000, 2, 1, 8'h11};
    tbl[4] = '{"mixed",    2, 1'b1, 8'h0F, 2'b00, 16'h0000, 24'h008001, 1'b1, 24'h000F00, 1, 0, 8'h01};
    tbl[5] = '{"three",    3, 1'b1, 8'hFF, 2'b11, 16'h6BC6, 24'h00FFA5, 1'b1, 24'hFFC66B, 0, 0, 8'hA5};

    wb_rst_i   = 1'b1;
    spi_sclk   = 1'b0;
    spi_csb    = 1'b1;
    spi_mosi   = 1'b0;
    tx_data    = '0;
    tx_valid   = 1'b0;
    rx_ready_i = 1'b1;
    repeat (3) tick();
    chk1("rst_miso", spi_miso_o, 1'b0);
    chk1("rst_oeb", spi_miso_oeb_o, 1'b1);
    chk1("rst_tx_ready", tx_ready_o, 1'b1);
    chk("rst_rx_data", 32'(rx_data_o), 32'h0);
    chk1("rst_rx_valid", rx_valid_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    wb_rst_i = 1'b0;
    repeat (3) tick();

    for (int v = 0; v < 6; v++)
      run_and_check(tbl[v].tag, tbl[v].nb, tbl[v].pre_en, tbl[v].pre, tbl[v].push_en,
                    tbl[v].pdat, tbl[v].mosi, tbl[v].rdy, tbl[v].exp_miso, tbl[v].exp_und,
                    tbl[v].exp_ovr, tbl[v].exp_rx);

    // Frame aborted after 5 bits, then a clean frame.
    rx_ready_i = 1'b1;
    base = rx_q.size();
    spi_xfer(5, 32'h0000001A, mi);
    repeat (8) tick();
    chk("partial_rx_count", rx_q.size() - base, 0);
    chk1("partial_rx_valid", rx_valid_o, 1'b0);
    chk1("partial_busy", busy_o, 1'b0);
    run_and_check("after_partial", 1, 1'b1, 8'h7E, 2'b00, 16'h0, 24'h000081, 1'b1,
                  24'h00007E, 0, 0, 8'h81);

    // Asynchronous reset in the middle of a byte with a word waiting in the holding register.
    tx_push(8'h99);
    fork
      spi_xfer(8, 32'h000000E7, mi);
      begin
        repeat (10) tick();
        tx_push(8'h5A);
        repeat (20) tick();
        #1 wb_rst_i = 1'b1;
        #1;
        chk1("arst_miso", spi_miso_o, 1'b0);
        chk1("arst_oeb", spi_miso_oeb_o, 1'b1);
        chk1("arst_tx_ready", tx_ready_o, 1'b1);
        chk("arst_rx_data", 32'(rx_data_o), 32'h0);
        chk1("arst_rx_valid", rx_valid_o, 1'b0);
        chk1("arst_overrun", rx_overrun_o, 1'b0);
        chk1("arst_underrun", tx_underrun_o, 1'b0);
        chk1("arst_busy", busy_o, 1'b0);
      end
    join
    repeat (2) tick();
    wb_rst_i = 1'b0;
    repeat (4) tick();
    run_and_check("post_reset", 1, 1'b1, 8'hC3, 2'b00, 16'h0, 24'h00005C, 1'b1,
                  24'h0000C3, 0, 0, 8'h5C);

    // Random frames against a word-level model: slot k transmits the word made available for it
    // (preload for slot 0, mid-frame push for later slots) or 0 with an underrun.
    for (int r = 0; r < 20; r++) begin
      int          nb, exp_und, exp_ovr;
      bit          pre_en, rdy, slot_full;
      logic [7:0]  pre, slot_val, exp_rx;
      logic [1:0]  push_en;
      logic [15:0] pdat;
      logic [23:0] mosi, exp_miso;
      nb      = $urandom_range(1, 3);
      pre_en  = 1'($urandom_range(0, 1));
      pre     = 8'($urandom);
      push_en = 2'($urandom);
      pdat    = 16'($urandom);
      mosi    = 24'($urandom) & ((24'h1 << (8 * nb)) - 24'h1);
      rdy     = ($urandom_range(0, 3) != 0);
      exp_miso = '0;
      exp_und  = 0;
      for (int k = 0; k < nb; k++) begin
        slot_full = (k == 0) ? pre_en : push_en[k-1];
        slot_val  = (k == 0) ? pre : pdat[8*(k-1) +: 8];
        exp_miso  = (exp_miso << 8) | 24'(slot_full ? slot_val : 8'h00);
        if (!slot_full) exp_und++;
      end
      exp_ovr = rdy ? 0 : nb - 1;
      exp_rx  = rdy ? mosi[7:0] : mosi[8*(nb-1) +: 8];
      run_and_check($sformatf("rand%0d", r), nb, pre_en, pre, push_en, pdat, mosi, rdy,
                    exp_miso, exp_und, exp_ovr, exp_rx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
